// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command sequencer.
// Holds the command and status codes, the request/response frame lengths and
// the sequencer FSM state encoding.
package serial_cmd_pkg;

  // Request command codes
  localparam logic [7:0] CmdRead  = 8'h01;
  localparam logic [7:0] CmdWrite = 8'h02;

  // Response status codes
  localparam logic [7:0] StsOk         = 8'h00;
  localparam logic [7:0] StsUnknownCmd = 8'h01;
  localparam logic [7:0] StsBadChk     = 8'h02;
  localparam logic [7:0] StsRxErr      = 8'h03;
  localparam logic [7:0] StsBadAddr    = 8'h04;

  // Frame lengths in bytes, SOF included
  localparam logic [2:0] ReadFrameLen  = 3'd4;
  localparam logic [2:0] WriteFrameLen = 3'd5;
  localparam logic [2:0] RespFrameLen  = 3'd5;

  typedef enum logic [3:0] {
    StIdle,
    StRxReq,
    StRxWait,
    StParse,
    StExecRd,
    StExecWr,
    StResp,
    StTxLoad,
    StTxWaitCopy,
    StTxGap,
    StTxEnd
  } state_e;

endpackage

// File: rtl/serial_frame_checker.sv
// Running XOR checksum and status-priority encoder for one request frame.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - start of a new frame (SOF accepted)
//   byte_valid  - byte_data/byte_err carry an in-frame byte this cycle
//   byte_data   - frame byte after SOF (CMD, ADDR, [DATA], CHK)
//   byte_err    - receiver error flag for byte_data
//   cmd, addr   - captured CMD and ADDR of the current frame
//   status      - response status for the bytes seen so far
module serial_frame_checker
  import serial_cmd_pkg::*;
#(
  parameter int unsigned REG_COUNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  input  logic [7:0] cmd,
  input  logic [7:0] addr,
  output logic [7:0] status
);

  logic [7:0] xor_q;
  logic       err_q;

  // CHK is included in the running XOR, so a good frame XORs to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= 8'h00;
      err_q <= 1'b0;
    end else if (clear) begin
      xor_q <= 8'h00;
      err_q <= 1'b0;
    end else if (byte_valid) begin
      xor_q <= xor_q ^ byte_data;
      err_q <= err_q | byte_err;
    end
  end

  always_comb begin
    status = StsOk;
    if (err_q) begin
      status = StsRxErr;
    end else if (xor_q != 8'h00) begin
      status = StsBadChk;
    end else if (cmd != CmdRead && cmd != CmdWrite) begin
      status = StsUnknownCmd;
    end else if (32'(addr) >= REG_COUNT) begin
      status = StsBadAddr;
    end
  end

endmodule

// File: rtl/serial_cmd_sequencer.sv
// Command-frame controller between the rs232 byte interfaces and a register bus.
// Hunts for SOF, parses a read/write request, executes it on the register bus
// and sends a 5-byte response frame (RESP_SOF, STATUS, ADDR, DATA, CHK).
// Ports:
//   rx_byte_received/rx_data/rx_err/rx_read - rs232 receive FIFO read side
//   tx_transaction/tx_data/tx_data_ready/tx_data_copied/tx_busy - transmitter load side
//   reg_addr/reg_wdata/reg_we/reg_re/reg_rdata - register bus (rdata 1 cycle after re)
//   busy      - not idle
//   cmd_done  - pulse when a response frame has fully gone out
//   err_count - saturating count of rejected or aborted frames
module serial_cmd_sequencer
  import serial_cmd_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter logic [7:0]  RESP_SOF_BYTE  = 8'h5A,
  parameter int unsigned REG_COUNT      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_byte_received,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       rx_read,
  output logic       tx_transaction,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  input  logic       tx_data_copied,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       cmd_done,
  output logic [7:0] err_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [2:0]        rx_idx_q, rx_idx_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;
  logic              chk_clear, chk_valid;
  logic [7:0]        chk_status;
  logic [2:0]        frame_len;
  logic [7:0]        resp_byte;

  serial_frame_checker #(
    .REG_COUNT (REG_COUNT)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (chk_clear),
    .byte_valid (chk_valid),
    .byte_data  (rx_data),
    .byte_err   (rx_err),
    .cmd        (cmd_q),
    .addr       (addr_q),
    .status     (chk_status)
  );

  // Only consulted from index 3 onward, by which time CMD is captured.
  assign frame_len = (cmd_q == CmdWrite) ? WriteFrameLen : ReadFrameLen;

  always_comb begin
    unique case (tx_idx_q)
      3'd0:    resp_byte = RESP_SOF_BYTE;
      3'd1:    resp_byte = status_q;
      3'd2:    resp_byte = addr_q;
      3'd3:    resp_byte = resp_data_q;
      default: resp_byte = status_q ^ addr_q ^ resp_data_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rx_idx_d       = rx_idx_q;
    tx_idx_d       = tx_idx_q;
    tmo_d          = tmo_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    data_d         = data_q;
    status_d       = status_q;
    resp_data_d    = resp_data_q;
    err_inc        = 1'b0;
    chk_clear      = 1'b0;
    chk_valid      = 1'b0;
    rx_read        = 1'b0;
    reg_we         = 1'b0;
    reg_re         = 1'b0;
    cmd_done       = 1'b0;
    tx_transaction = 1'b0;
    tx_data_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_byte_received) begin
          rx_read  = 1'b1;
          rx_idx_d = 3'd0;
          state_d  = StRxWait;
        end
      end
      StRxReq: begin
        if (rx_byte_received) begin
          rx_read = 1'b1;
          tmo_d   = '0;
          state_d = StRxWait;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          // Silent abort: no response frame
          err_inc = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRxWait: begin
        if (rx_idx_q == 3'd0) begin
          if (rx_data == SOF_BYTE) begin
            chk_clear = 1'b1;
            rx_idx_d  = 3'd1;
            tmo_d     = '0;
            state_d   = StRxReq;
          end else begin
            state_d = StIdle;
          end
        end else begin
          chk_valid = 1'b1;
          case (rx_idx_q)
            3'd1:    cmd_d  = rx_data;
            3'd2:    addr_d = rx_data;
            3'd3:    if (cmd_q == CmdWrite) data_d = rx_data;
            default: ;
          endcase
          rx_idx_d = rx_idx_q + 3'd1;
          state_d  = (rx_idx_q + 3'd1 == frame_len) ? StParse : StRxReq;
        end
      end
      StParse: begin
        status_d = chk_status;
        if (chk_status != StsOk) begin
          err_inc = 1'b1;
          state_d = StResp;
        end else if (cmd_q == CmdRead) begin
          state_d = StExecRd;
        end else begin
          state_d = StExecWr;
        end
      end
      StExecRd: begin
        reg_re  = 1'b1;
        state_d = StResp;
      end
      StExecWr: begin
        reg_we  = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        // For a read this is the cycle after reg_re, when reg_rdata is valid.
        if (status_q != StsOk) begin
          resp_data_d = 8'h00;
        end else if (cmd_q == CmdRead) begin
          resp_data_d = reg_rdata;
        end else begin
          resp_data_d = data_q;
        end
        tx_idx_d = 3'd0;
        state_d  = StTxLoad;
      end
      StTxLoad: begin
        tx_transaction = 1'b1;
        state_d        = StTxWaitCopy;
      end
      StTxWaitCopy: begin
        tx_transaction = 1'b1;
        tx_data_ready  = 1'b1;
        if (tx_data_copied) begin
          tx_idx_d = tx_idx_q + 3'd1;
          state_d  = (tx_idx_q == RespFrameLen - 3'd1) ? StTxEnd : StTxGap;
        end
      end
      StTxGap: begin
        tx_transaction = 1'b1;
        state_d        = StTxLoad;
      end
      StTxEnd: begin
        if (!tx_busy) begin
          cmd_done = 1'b1;
          state_d  = StIdle;
        end else begin
          tx_transaction = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rx_idx_q    <= 3'd0;
      tx_idx_q    <= 3'd0;
      tmo_q       <= '0;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      status_q    <= 8'h00;
      resp_data_q <= 8'h00;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      rx_idx_q    <= rx_idx_d;
      tx_idx_q    <= tx_idx_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      status_q    <= status_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = tx_transaction ? resp_byte : 8'h00;
  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign busy      = (state_q != StIdle);
  assign err_count = err_q;

endmodule

// File: tb/tb_serial_cmd_sequencer.sv
module tb_serial_cmd_sequencer;

  localparam int unsigned Tmo = 43400;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_byte_received;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_read;
  logic       tx_transaction;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       cmd_done;
  logic [7:0] err_count;

  serial_cmd_sequencer #(
    .SOF_BYTE       (8'hA5),
    .RESP_SOF_BYTE  (8'h5A),
    .REG_COUNT      (16),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_byte_received (rx_byte_received),
    .rx_data          (rx_data),
    .rx_err           (rx_err),
    .rx_read          (rx_read),
    .tx_transaction   (tx_transaction),
    .tx_data          (tx_data),
    .tx_data_ready    (tx_data_ready),
    .tx_data_copied   (tx_data_copied),
    .tx_busy          (tx_busy),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_we           (reg_we),
    .reg_re           (reg_re),
    .reg_rdata        (reg_rdata),
    .busy             (busy),
    .cmd_done         (cmd_done),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } reg_ev_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_q[$];
  logic       rx_e_q[$];
  logic [7:0] exp_tx[$];
  reg_ev_t    exp_reg[$];
  logic [7:0] board_mem[256];
  logic [7:0] model_mem[256];
  int         exp_err   = 0;
  int         exp_done  = 0;
  int         done_seen = 0;
  bit         stall_en  = 1'b0;

  function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endfunction

  task automatic push_raw(input logic [7:0] b, input logic e);
    rx_q.push_back(b);
    rx_e_q.push_back(e);
  endtask

  // Reference model: derives the whole response of one request frame from its bytes.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] chk, input int err_pos, input int garbage);
    int         len;
    logic [7:0] st;
    logic [7:0] d;
    logic [7:0] b;
    bit         chk_ok;
    bit         bad_err;
    logic [7:0] fb[5];
    len = (cmd == 8'h02) ? 5 : 4;
    fb[0] = 8'hA5;
    fb[1] = cmd;
    fb[2] = addr;
    fb[3] = (len == 5) ? data : chk;
    fb[4] = chk;
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h11;
      push_raw(b, 1'b0);
    end
    for (int i = 0; i < len; i++) push_raw(fb[i], (i == err_pos) && (i != 0));
    bad_err = (err_pos > 0) && (err_pos < len);
    chk_ok  = (len == 5) ? (chk == (cmd ^ addr ^ data)) : (chk == (cmd ^ addr));
    if (bad_err)                         st = 8'h03;
    else if (!chk_ok)                    st = 8'h02;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h01;
    else if (addr >= 8'd16)              st = 8'h04;
    else                                 st = 8'h00;
    if (st != 8'h00) begin
      d = 8'h00;
      if (exp_err < 255) exp_err++;
    end else if (cmd == 8'h01) begin
      d = model_mem[addr];
      exp_reg.push_back('{we: 1'b0, addr: addr, wdata: 8'h00});
    end else begin
      d = data;
      model_mem[addr] = data;
      exp_reg.push_back('{we: 1'b1, addr: addr, wdata: data});
    end
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(st);
    exp_tx.push_back(addr);
    exp_tx.push_back(d);
    exp_tx.push_back(st ^ addr ^ d);
    exp_done++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(rx_q.size() == 0 && !busy && !rx_read && exp_tx.size() == 0) && i < budget);
    n_tests++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  // rs232 receive FIFO model
  initial begin
    logic rd;
    rx_byte_received = 1'b0;
    rx_data          = 8'h00;
    rx_err           = 1'b0;
    forever begin
      @(negedge clk);
      rd = rx_read;
      @(posedge clk);
      #1;
      if (rd && rx_q.size() > 0) begin
        rx_data = rx_q.pop_front();
        rx_err  = rx_e_q.pop_front();
      end
      rx_byte_received = (rx_q.size() != 0);
    end
  end

  // Transmitter model: copies after a random delay, stays busy a few cycles
  initial begin
    int busy_cnt;
    int delay;
    int nbyte;
    busy_cnt       = 0;
    delay          = -1;
    nbyte          = 0;
    tx_data_copied = 1'b0;
    tx_busy        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_data_copied = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (!tx_transaction) nbyte = 0;
      if (tx_data_ready) begin
        if (delay < 0) delay = (stall_en && nbyte == 2) ? 1000 : int'($urandom_range(0, 3));
        if (delay == 0) begin
          tx_data_copied = 1'b1;
          busy_cnt       = int'($urandom_range(2, 8));
          nbyte++;
          delay = -1;
        end else begin
          delay--;
        end
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  // Board register file: read data appears exactly one cycle after reg_re
  initial begin
    logic [7:0] a;
    reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (reg_we) board_mem[reg_addr] = reg_wdata;
      if (reg_re) begin
        a = reg_addr;
        @(posedge clk);
        #1 reg_rdata = board_mem[a];
        @(posedge clk);
        #1 reg_rdata = 8'($urandom);
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_rd;
    logic       prev_ready;
    logic       prev_copied;
    logic [7:0] e;
    reg_ev_t    ev;
    prev_rd     = 1'b0;
    prev_ready  = 1'b0;
    prev_copied = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_data_ready && exp_tx.size() > 0) check8("tx_data_held", tx_data, exp_tx[0]);
        if (tx_data_ready && tx_data_copied) begin
          n_tests++;
          if (exp_tx.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_data);
          end else begin
            e = exp_tx.pop_front();
            if (tx_data !== e) begin
              n_fail++;
              $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
            end
          end
        end
        if (prev_ready && prev_copied) check8("tx_gap", {7'd0, tx_data_ready}, 8'h00);
        if (reg_we || reg_re) begin
          n_tests++;
          if (exp_reg.size() == 0) begin
            n_fail++;
            $display("FAIL reg_unexpected: got we=%0b re=%0b addr=%02h, required none",
                     reg_we, reg_re, reg_addr);
          end else begin
            ev = exp_reg.pop_front();
            if (reg_we !== ev.we || reg_re !== !ev.we || reg_addr !== ev.addr ||
                (ev.we && reg_wdata !== ev.wdata)) begin
              n_fail++;
              $display("FAIL reg_access: got we=%0b addr=%02h wdata=%02h expected we=%0b addr=%02h wdata=%02h",
                       reg_we, reg_addr, reg_wdata, ev.we, ev.addr, ev.wdata);
            end
          end
        end
        if (prev_rd || tx_transaction) check8("rx_read_blocked", {7'd0, rx_read}, 8'h00);
        if (cmd_done) done_seen++;
        prev_rd     = rx_read;
        prev_ready  = tx_data_ready;
        prev_copied = tx_data_copied;
      end else begin
        prev_rd     = 1'b0;
        prev_ready  = 1'b0;
        prev_copied = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] chk;
    int         r;
    int         i;
    for (int k = 0; k < 256; k++) begin
      v            = 8'($urandom);
      board_mem[k] = v;
      model_mem[k] = v;
    end

    rst = 1'b1;
    #2;
    check8("rst_rx_read", {7'd0, rx_read}, 8'h00);
    check8("rst_tx_transaction", {7'd0, tx_transaction}, 8'h00);
    check8("rst_tx_data", tx_data, 8'h00);
    check8("rst_tx_data_ready", {7'd0, tx_data_ready}, 8'h00);
    check8("rst_reg_addr", reg_addr, 8'h00);
    check8("rst_reg_wdata", reg_wdata, 8'h00);
    check8("rst_reg_we", {7'd0, reg_we}, 8'h00);
    check8("rst_reg_re", {7'd0, reg_re}, 8'h00);
    check8("rst_busy", {7'd0, busy}, 8'h00);
    check8("rst_cmd_done", {7'd0, cmd_done}, 8'h00);
    check8("rst_err_count", err_count, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames
    send_frame(8'h02, 8'h03, 8'h3C, 8'h3D, 0, 0);
    wait_idle("write_ok", 500);
    check8("err_after_write", err_count, 8'(exp_err));
    board_mem[5] = 8'h77;
    model_mem[5] = 8'h77;
    send_frame(8'h01, 8'h05, 8'h00, 8'h04, 0, 0);
    wait_idle("read_ok", 500);
    send_frame(8'h02, 8'h03, 8'h3C, 8'h00, 0, 0);
    wait_idle("bad_chk", 500);
    check8("err_after_bad_chk", err_count, 8'(exp_err));
    send_frame(8'h07, 8'h01, 8'h00, 8'h06, 0, 0);
    wait_idle("unknown_cmd", 500);
    check8("err_after_unknown", err_count, 8'(exp_err));
    push_raw(8'h11, 1'b0);
    push_raw(8'h22, 1'b0);
    send_frame(8'h02, 8'h20, 8'h3C, 8'h1E, 0, 0);
    wait_idle("bad_addr", 500);
    check8("err_after_bad_addr", err_count, 8'(exp_err));
    send_frame(8'h01, 8'h02, 8'h00, 8'h03, 2, 0);
    wait_idle("rx_err", 500);
    check8("err_after_rx_err", err_count, 8'(exp_err));

    // In-frame timeout
    push_raw(8'hA5, 1'b0);
    push_raw(8'h02, 1'b0);
    i = 0;
    while (!busy && i < 50) begin
      @(negedge clk);
      i++;
    end
    repeat (Tmo - 100) @(negedge clk);
    check8("tmo_not_early", {7'd0, busy}, 8'h01);
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check8("tmo_busy_dropped", {7'd0, busy}, 8'h00);
    exp_err++;
    check8("err_after_tmo", err_count, 8'(exp_err));
    send_frame(8'h02, 8'h0A, 8'h5C, 8'h02 ^ 8'h0A ^ 8'h5C, 0, 0);
    wait_idle("after_tmo", 500);

    // Transmitter stall with a second frame already queued in the FIFO
    stall_en = 1'b1;
    send_frame(8'h01, 8'h03, 8'h00, 8'h02, 0, 0);
    i = 0;
    while (!tx_transaction && i < 200) begin
      @(negedge clk);
      i++;
    end
    send_frame(8'h02, 8'h07, 8'h99, 8'h02 ^ 8'h07 ^ 8'h99, 0, 1);
    wait_idle("stall", 3000);
    stall_en = 1'b0;
    check8("err_after_stall", err_count, 8'(exp_err));

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      r    = int'($urandom_range(0, 9));
      cmd  = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      data = 8'($urandom);
      chk  = (cmd == 8'h02) ? (cmd ^ addr ^ data) : (cmd ^ addr);
      if ($urandom_range(0, 7) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      send_frame(cmd, addr, data, chk,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0,
                 int'($urandom_range(0, 2)));
      wait_idle("random_frame", 800);
      check8("err_random", err_count, 8'(exp_err));
    end
    check8("cmd_done_count", 8'(done_seen), 8'(exp_done));

    // Asynchronous reset in the middle of a response
    send_frame(8'h01, 8'h04, 8'h00, 8'h05, 0, 0);
    i = 0;
    while (!tx_transaction && i < 200) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check8("midrst_tx_transaction", {7'd0, tx_transaction}, 8'h00);
    check8("midrst_tx_data_ready", {7'd0, tx_data_ready}, 8'h00);
    check8("midrst_busy", {7'd0, busy}, 8'h00);
    check8("midrst_err_count", err_count, 8'h00);
    rx_q.delete();
    rx_e_q.delete();
    exp_tx.delete();
    exp_reg.delete();
    exp_err  = 0;
    exp_done = done_seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_frame(8'h02, 8'h01, 8'h42, 8'h02 ^ 8'h01 ^ 8'h42, 0, 0);
    wait_idle("after_reset", 500);
    check8("err_after_reset", err_count, 8'(exp_err));
    check8("cmd_done_final", 8'(done_seen), 8'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
